// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared opcodes, FSM states and PC-source codes for fetch_ctrl_seq
package fetch_ctrl_pkg;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_ALU_LO = 4'h1;
  localparam logic [3:0] OP_ALU_HI = 4'h8;
  localparam logic [3:0] OP_LDI    = 4'h9;
  localparam logic [3:0] OP_LD     = 4'hA;
  localparam logic [3:0] OP_ST     = 4'hB;
  localparam logic [3:0] OP_JMP    = 4'hC;
  localparam logic [3:0] OP_BZ     = 4'hD;
  localparam logic [3:0] OP_CALL   = 4'hE;
  localparam logic [3:0] OP_SYS    = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_HALT   = 3'd4
  } state_e;

  localparam logic [1:0] PCSRC_HOLD = 2'd0;
  localparam logic [1:0] PCSRC_INC  = 2'd1;
  localparam logic [1:0] PCSRC_TGT  = 2'd2;
  localparam logic [1:0] PCSRC_LR   = 2'd3;

endpackage

// File: rtl/fetch_ctrl_decode.sv
// rtl/fetch_ctrl_decode.sv - combinational opcode-to-instruction-class decoder
module fetch_ctrl_decode
  import fetch_ctrl_pkg::*;
(
  input  logic [3:0] op_i,
  input  logic       sys_sel_i,
  output logic       is_alu_o,
  output logic       is_ldi_o,
  output logic       is_mem_o,
  output logic       is_ld_o,
  output logic       is_br_o,
  output logic       is_call_o,
  output logic       is_ret_o,
  output logic       is_halt_o
);

  // OP_SYS is split by IR[0]: 0 returns through the link register, 1 halts.
  assign is_alu_o  = (op_i >= OP_ALU_LO) && (op_i <= OP_ALU_HI);
  assign is_ldi_o  = (op_i == OP_LDI);
  assign is_mem_o  = (op_i == OP_LD) || (op_i == OP_ST);
  assign is_ld_o   = (op_i == OP_LD);
  assign is_br_o   = (op_i == OP_JMP) || (op_i == OP_BZ);
  assign is_call_o = (op_i == OP_CALL);
  assign is_ret_o  = (op_i == OP_SYS) && !sys_sel_i;
  assign is_halt_o = (op_i == OP_SYS) && sys_sel_i;

endmodule

// File: rtl/fetch_ctrl_seq.sv
// rtl/fetch_ctrl_seq.sv - multi-cycle instruction sequencer; FETCH_CTRL_PERF_CNT_EN adds the retired counter
module fetch_ctrl_seq
  import fetch_ctrl_pkg::*;
#(
  parameter state_e      RST_STATE   = S_FETCH,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Oi,
  input  logic        zero_flag,
  input  logic        mem_ready,
  output logic        PCCR,
  output logic [1:0]  mux1CR,
  output logic        LRCR,
  output logic [7:0]  target,
  output logic [3:0]  alu_op,
  output logic [2:0]  rd,
  output logic [2:0]  rs,
  output logic [7:0]  imm,
  output logic        imm_sel,
  output logic        rf_we,
  output logic        mem_re,
  output logic        mem_we,
  output logic        halted
`ifdef FETCH_CTRL_PERF_CNT_EN
  ,
  output logic [15:0] retired
`endif
);

  localparam logic [3:0] TIMEOUT_LAST = 4'(MEM_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [3:0]  cnt_q, cnt_d;

  logic is_alu, is_ldi, is_mem, is_ld, is_br, is_call, is_ret, is_halt;

  fetch_ctrl_decode u_decode (
    .op_i      (ir_q[15:12]),
    .sys_sel_i (ir_q[0]),
    .is_alu_o  (is_alu),
    .is_ldi_o  (is_ldi),
    .is_mem_o  (is_mem),
    .is_ld_o   (is_ld),
    .is_br_o   (is_br),
    .is_call_o (is_call),
    .is_ret_o  (is_ret),
    .is_halt_o (is_halt)
  );

  assign target = ir_q[7:0];
  assign imm    = ir_q[7:0];
  assign rd     = ir_q[11:9];
  assign rs     = ir_q[8:6];
  assign alu_op = is_alu ? ir_q[15:12] : 4'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RST_STATE;
      ir_q    <= 16'h0000;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    PCCR    = 1'b0;
    mux1CR  = PCSRC_HOLD;
    LRCR    = 1'b0;
    imm_sel = 1'b0;
    rf_we   = 1'b0;
    mem_re  = 1'b0;
    mem_we  = 1'b0;
    halted  = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        ir_d    = Oi;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        cnt_d = 4'd0;
        if (is_mem)       state_d = S_MEM;
        else if (is_halt) state_d = S_HALT;
        else              state_d = S_EXEC;
      end
      S_EXEC: begin
        PCCR    = 1'b1;
        mux1CR  = PCSRC_INC;
        rf_we   = is_alu || is_ldi;
        imm_sel = is_ldi;
        if (is_br && ((ir_q[15:12] == OP_JMP) || zero_flag)) mux1CR = PCSRC_TGT;
        if (is_call) begin
          LRCR   = 1'b1;
          mux1CR = PCSRC_TGT;
        end
        if (is_ret) mux1CR = PCSRC_LR;
        state_d = S_FETCH;
      end
      S_MEM: begin
        mem_re = is_ld;
        mem_we = !is_ld;
        // Completion takes priority over a timeout landing in the same cycle.
        if (mem_ready) begin
          PCCR    = 1'b1;
          mux1CR  = PCSRC_INC;
          rf_we   = is_ld;
          state_d = S_FETCH;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = S_HALT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

`ifdef FETCH_CTRL_PERF_CNT_EN
  logic [15:0] retired_q;

  // PCCR is never raised in S_HALT, so the count freezes there without extra logic.
  always_ff @(posedge clk) begin
    if (rst)       retired_q <= 16'd0;
    else if (PCCR) retired_q <= retired_q + 16'd1;
  end

  assign retired = retired_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl_seq.sv
// tb/tb_fetch_ctrl_seq.sv - scoreboard bench for fetch_ctrl_seq
module tb_fetch_ctrl_seq;

  typedef struct packed {
    logic [1:0] mux;
    logic       lr;
    logic       we;
    logic       isel;
    logic [3:0] alu;
    logic [2:0] rd;
    logic [2:0] rs;
    logic [7:0] tgt;
    logic [7:0] imm;
    logic       re;
    logic       wr;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] Oi;
  logic        zero_flag;
  logic        mem_ready;
  logic        PCCR;
  logic [1:0]  mux1CR;
  logic        LRCR;
  logic [7:0]  target;
  logic [3:0]  alu_op;
  logic [2:0]  rd;
  logic [2:0]  rs;
  logic [7:0]  imm;
  logic        imm_sel;
  logic        rf_we;
  logic        mem_re;
  logic        mem_we;
  logic        halted;
`ifdef FETCH_CTRL_PERF_CNT_EN
  logic [15:0] retired;
  logic [15:0] retired_snap;
`endif

  int    checks = 0;
  int    errors = 0;
  resp_t exp_q[$];

  fetch_ctrl_seq dut (
    .clk       (clk),
    .rst       (rst),
    .Oi        (Oi),
    .zero_flag (zero_flag),
    .mem_ready (mem_ready),
    .PCCR      (PCCR),
    .mux1CR    (mux1CR),
    .LRCR      (LRCR),
    .target    (target),
    .alu_op    (alu_op),
    .rd        (rd),
    .rs        (rs),
    .imm       (imm),
    .imm_sel   (imm_sel),
    .rf_we     (rf_we),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .halted    (halted)
`ifdef FETCH_CTRL_PERF_CNT_EN
    ,
    .retired   (retired)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic resp_t mk(input logic [1:0] mux, input logic lr, input logic we,
                               input logic isel, input logic [3:0] alu, input logic [2:0] r_d,
                               input logic [2:0] r_s, input logic [7:0] tgt,
                               input logic re, input logic wr);
    resp_t r;
    r.mux = mux; r.lr = lr; r.we = we; r.isel = isel; r.alu = alu;
    r.rd = r_d; r.rs = r_s; r.tgt = tgt; r.imm = tgt; r.re = re; r.wr = wr;
    return r;
  endfunction

  function automatic resp_t sample();
    resp_t r;
    r.mux = mux1CR; r.lr = LRCR; r.we = rf_we; r.isel = imm_sel; r.alu = alu_op;
    r.rd = rd; r.rs = rs; r.tgt = target; r.imm = imm; r.re = mem_re; r.wr = mem_we;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every PCCR pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (!rst && PCCR) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pccr: got pulse with %h expected none", sample());
      end else begin
        chk("pccr_resp", 64'(sample()), 64'(exp_q.pop_front()));
      end
    end else if (!rst && mux1CR != 2'd0) begin
      chk("mux_without_pccr", 64'(mux1CR), 64'd0);
    end
  end

  // Starts and ends at the FETCH cycle; checks the PCCR pulse lands in cycle 3.
  task automatic exec_instr(input string name, input logic [15:0] oi, input logic zf, input resp_t exp);
    Oi = oi;
    zero_flag = zf;
    exp_q.push_back(exp);
    tick();
    chk({name, "_decode_pccr"}, 64'(PCCR), 64'd0);
    tick();
    chk({name, "_exec_pccr"}, 64'(PCCR), 64'd1);
    tick();
  endtask

  initial begin
    int n;
    rst = 1'b1;
    Oi = 16'h1A40;
    zero_flag = 1'b0;
    mem_ready = 1'b0;
    repeat (5) tick();
    chk("reset_outputs",
        {PCCR, mux1CR, LRCR, target, alu_op, rd, rs, imm, imm_sel, rf_we, mem_re, mem_we, halted},
        '0);
`ifdef FETCH_CTRL_PERF_CNT_EN
    chk("reset_retired", 64'(retired), 64'd0);
`endif
    rst = 1'b0;

    exec_instr("alu1", 16'h1A40, 1'b0, mk(2'd1, 0, 1, 0, 4'd1, 3'd5, 3'd1, 8'h40, 0, 0));
    chk("alu1_single_pulse", 64'(PCCR), 64'd0);
    exec_instr("bz_taken", 16'hD020, 1'b1, mk(2'd2, 0, 0, 0, 4'd0, 3'd0, 3'd0, 8'h20, 0, 0));
    exec_instr("bz_not",   16'hD020, 1'b0, mk(2'd1, 0, 0, 0, 4'd0, 3'd0, 3'd0, 8'h20, 0, 0));
    exec_instr("call",     16'hE033, 1'b0, mk(2'd2, 1, 0, 0, 4'd0, 3'd0, 3'd0, 8'h33, 0, 0));
    exec_instr("ret",      16'hF000, 1'b0, mk(2'd3, 0, 0, 0, 4'd0, 3'd0, 3'd0, 8'h00, 0, 0));
    exec_instr("ldi",      16'h9A7F, 1'b0, mk(2'd1, 0, 1, 1, 4'd0, 3'd5, 3'd1, 8'h7F, 0, 0));
    exec_instr("jmp",      16'hC0AB, 1'b0, mk(2'd2, 0, 0, 0, 4'd0, 3'd0, 3'd2, 8'hAB, 0, 0));
    exec_instr("nop",      16'h0000, 1'b1, mk(2'd1, 0, 0, 0, 4'd0, 3'd0, 3'd0, 8'h00, 0, 0));
    exec_instr("alu8",     16'h8E00, 1'b0, mk(2'd1, 0, 1, 0, 4'd8, 3'd7, 3'd0, 8'h00, 0, 0));

    // LD with mem_ready raised on the fifth request cycle.
    Oi = 16'hA600;
    exp_q.push_back(mk(2'd1, 0, 1, 0, 4'd0, 3'd3, 3'd0, 8'h00, 1, 0));
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 4) mem_ready = 1'b1;
      chk("ld_mem_re_high", 64'(mem_re), 64'd1);
      if (i < 4) chk("ld_no_early_pccr", 64'(PCCR), 64'd0);
      tick();
    end
    mem_ready = 1'b0;
    chk("ld_mem_re_drop", 64'(mem_re), 64'd0);

    // ST with mem_ready never raised: times out into HALT.
    Oi = 16'hB000;
    tick();
    tick();
    n = 0;
    for (int c = 0; c < 40 && !halted; c++) begin
      if (mem_we) n++;
      tick();
    end
    chk("st_timeout_we_cycles", 64'(n), 64'd15);
    chk("st_timeout_halted", 64'(halted), 64'd1);
    chk("st_timeout_we_off", 64'(mem_we), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("after_reset_not_halted", 64'(halted), 64'd0);

    // ST interrupted by reset while waiting in S_MEM.
    Oi = 16'hB000;
    tick();
    tick();
    tick();
    tick();
    chk("st_mid_we", 64'(mem_we), 64'd1);
    rst = 1'b1;
    tick();
    chk("st_rst_we_drop", 64'(mem_we), 64'd0);
    chk("st_rst_pccr", 64'(PCCR), 64'd0);
    rst = 1'b0;
    exec_instr("nop_after_rst", 16'h0000, 1'b0, mk(2'd1, 0, 0, 0, 4'd0, 3'd0, 3'd0, 8'h00, 0, 0));

    // HALT then stimulus churn.
    Oi = 16'hF001;
    tick();
    chk("halt_decode_not_halted", 64'(halted), 64'd0);
    tick();
    chk("halt_asserted", 64'(halted), 64'd1);
`ifdef FETCH_CTRL_PERF_CNT_EN
    retired_snap = retired;
`endif
    for (int c = 0; c < 20; c++) begin
      Oi = 16'(c * 16'h1357);
      mem_ready = c[0];
      zero_flag = c[1];
      #1;
      chk("halt_quiet",
          {halted, PCCR, mux1CR, LRCR, imm_sel, rf_we, mem_re, mem_we},
          {1'b1, 8'h00});
      tick();
    end
`ifdef FETCH_CTRL_PERF_CNT_EN
    chk("halt_retired_frozen", 64'(retired), 64'(retired_snap));
`endif
    mem_ready = 1'b0;

    tick();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl_seq.md
Name: fetch_ctrl_seq

Overview:
Instruction-sequencing controller at the consuming end of the IF stage interface. It captures the 16-bit instruction word Oi from IF, decodes it and drives IF's control inputs (PCCR, mux1CR, LRCR) to choose the next PC. It also emits datapath strobes for the register file, ALU and data memory. It is a multi-cycle FSM: one instruction is in flight at a time, and there is no pipelining.

Parameters:
- RST_STATE, 0 (S_FETCH), state entered on reset
- MEM_TIMEOUT, 15, maximum cycles to wait in S_MEM before forcing S_HALT

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- Oi  in  16  instruction word from IF, valid during S_FETCH
- zero_flag  in  1  ALU zero flag, sampled in S_EXEC
- mem_ready  in  1  data-memory completion handshake
- PCCR  out  1  PC load enable to IF
- mux1CR  out  2  PC source to IF: 0 = hold, 1 = PC+1, 2 = target, 3 = link register
- LRCR  out  1  link-register load (captures PC+1) to IF
- target  out  8  jump/branch/call target, IR[7:0]
- alu_op  out  4  ALU operation, IR[15:12]; 0 when not ALU
- rd  out  3  destination register, IR[11:9]
- rs  out  3  source register, IR[8:6]
- imm  out  8  immediate, IR[7:0]
- imm_sel  out  1  register-file write data comes from imm
- rf_we  out  1  register-file write strobe
- mem_re  out  1  data-memory read request
- mem_we  out  1  data-memory write request
- halted  out  1  processor halted

Behaviour:
- Reset: state = S_FETCH and IR = 16'h0000. All outputs are 0 (mux1CR = 0), except rd/rs/imm/target, which follow IR and are therefore 0.
- Opcode map, IR[15:12]:
  - 0x0 NOP
  - 0x1–0x8 ALU, alu_op = opcode
  - 0x9 LDI
  - 0xA LD
  - 0xB ST
  - 0xC JMP
  - 0xD BZ
  - 0xE CALL
  - 0xF with IR[0] = 0 is RET; IR[0] = 1 is HALT
- States: S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT. Encoding is binary, 3 bits.
- S_FETCH: IR <= Oi; go to S_DECODE. All strobes are 0.
- S_DECODE: field outputs become valid; go to S_MEM for LD/ST, to S_HALT for HALT, otherwise to S_EXEC.
- S_EXEC: asserts exactly one PCCR pulse, then returns to S_FETCH.
  - NOP: mux1CR = 1.
  - ALU: rf_we = 1, mux1CR = 1.
  - LDI: rf_we = 1, imm_sel = 1, mux1CR = 1.
  - JMP: mux1CR = 2.
  - BZ: mux1CR = 2 if zero_flag = 1, else 1.
  - CALL: LRCR = 1 and mux1CR = 2 in the same cycle.
  - RET: mux1CR = 3.
- S_MEM:
  - mem_re (LD) or mem_we (ST) is held high until the cycle mem_ready = 1.
  - In that cycle: PCCR = 1, mux1CR = 1, rf_we = 1 for LD only; request drops next cycle; go to S_FETCH.
  - A wait counter (4 bits) increments each cycle. When it reaches MEM_TIMEOUT, go to S_HALT with no PCCR.
- mem_ready outside S_MEM is ignored.
- S_HALT: halted = 1, all strobes 0, mux1CR = 0. Only rst leaves this state.
- Latency: NOP/ALU/LDI/branch/CALL/RET take 3 cycles; LD/ST take 3 + N cycles, where N is the number of mem_ready wait cycles.
- PCCR is asserted at most once per instruction. mux1CR is 0 whenever PCCR = 0.
- rst wins over every event. Reset in S_MEM drops mem_re/mem_we in the next cycle and discards the instruction.

Optional Feature:
- Macro: FETCH_CTRL_PERF_CNT_EN.
- When defined:
  - adds output port retired[15:0], counting cycles in which PCCR = 1;
  - retired wraps from 16'hFFFF to 0;
  - rst clears it;
  - it freezes in S_HALT.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package fetch_ctrl_pkg holds:
  - opcode localparams OP_NOP..OP_SYS;
  - state encodings S_*;
  - PC source constants PCSRC_HOLD = 0, PCSRC_INC = 1, PCSRC_TGT = 2, PCSRC_LR = 3.
- Sub-module fetch_ctrl_decode is purely combinational. It maps IR to instruction class flags (is_alu, is_ldi, is_mem, is_ld, is_br, is_call, is_ret, is_halt).
- The FSM, IR register, timeout counter and output logic stay in fetch_ctrl_seq.

Test Plan:
- Reset: hold rst for 5 cycles, then release with Oi = 16'h1A40 (ALU op 1) → cycle 3 after release: rf_we = 1, alu_op = 1, rd = 5, rs = 1, PCCR = 1, mux1CR = 1; one pulse only.
- BZ: Oi = 16'hD020 with zero_flag = 1 → PCCR = 1, mux1CR = 2, target = 8'h20. Repeat with zero_flag = 0 → mux1CR = 1.
- CALL/RET: Oi = 16'hE033, then 16'hF000 → CALL EXEC cycle has LRCR = 1, mux1CR = 2, target = 8'h33; RET EXEC cycle has mux1CR = 3 and LRCR = 0.
- LD handshake: Oi = 16'hA600 with mem_ready raised 4 cycles after mem_re → mem_re stays high for 5 cycles. The final cycle has rf_we = 1, PCCR = 1, mux1CR = 1; mem_re = 0 the next cycle.
- Timeout and reset mid-op:
  - ST (16'hB000) with mem_ready held at 0 → after 15 cycles, halted = 1 and PCCR never pulses.
  - Second run: rst asserted during S_MEM → mem_we = 0 and state S_FETCH on the next cycle.
- HALT: Oi = 16'hF001 → halted = 1 from the cycle after S_DECODE. Strobes stay 0 for 20 cycles despite Oi changes. With FETCH_CTRL_PERF_CNT_EN, retired stays frozen.
